// File: rtl/synth_pkg.sv
// Shared synthesizer definitions: ADSR stage encoding, level limits and the
// sustain percentage-to-level conversion.
package synth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_stage_e;

  localparam logic [15:0] LEVEL_MAX     = 16'hFFFF;
  localparam logic [16:0] SUSTAIN_SCALE = 17'd655;
  localparam logic [6:0]  SUSTAIN_MAX   = 7'd100;

  // Percentages above 100 clamp, so the result never exceeds 65500.
  function automatic logic [16:0] sustain_to_level(input logic [6:0] pct);
    logic [6:0]  w_pct;
    logic [16:0] w_prod;
    w_pct  = (pct > SUSTAIN_MAX) ? SUSTAIN_MAX : pct;
    w_prod = 17'(w_pct) * SUSTAIN_SCALE;
    return w_prod;
  endfunction

endpackage

// File: rtl/adsr_rate_divider.sv
// Tick prescaler for one envelope stage: fires a step every (i_rate+1) ticks,
// restarts from zero on i_clear. A live rate below the count just wraps.
module adsr_rate_divider
  import synth_pkg::*;
#(
  parameter int RATE_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_tick,
  input  logic              i_clear,
  input  logic [RATE_W-1:0] i_rate,
  output logic              o_step
);

  logic [RATE_W-1:0] r_cnt;
  logic              w_hit;

  assign w_hit  = (r_cnt == i_rate);
  assign o_step = i_tick & w_hit & ~i_clear;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_hit ? '0 : r_cnt + RATE_W'(1);
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator with a 16-bit registered level output.
// Build option ADSR_RETRIGGER_EN: a gate rise restarts the attack from zero.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int LEVEL_STEP = 256,
  parameter int RATE_W     = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_tick,
  input  logic              i_gate,
  input  logic [RATE_W-1:0] i_attack,
  input  logic [RATE_W-1:0] i_decay,
  input  logic [6:0]        i_sustain,
  input  logic [RATE_W-1:0] i_release,
  output logic [15:0]       o_level,
  output logic [2:0]        o_stage,
  output logic              o_active
);

  localparam logic [16:0] STEP17  = 17'(LEVEL_STEP);
  localparam logic [16:0] LMAX17  = {1'b0, LEVEL_MAX};
  localparam logic [16:0] ATK_TOP = LMAX17 - STEP17;

  function automatic logic [15:0] sat_add(input logic [16:0] a, input logic [16:0] b);
    logic [17:0] w_sum;
    w_sum = {1'b0, a} + {1'b0, b};
    return (w_sum > {1'b0, LMAX17}) ? LEVEL_MAX : w_sum[15:0];
  endfunction

  function automatic logic [15:0] sat_sub(input logic [16:0] a, input logic [16:0] b);
    logic [16:0] w_dif;
    w_dif = a - b;
    return (b > a) ? 16'd0 : w_dif[15:0];
  endfunction

  adsr_stage_e       r_stage;
  logic [15:0]       r_level;
  logic              r_gate_q;
  logic              r_active;

  adsr_stage_e       w_stage_nxt;
  logic [15:0]       w_level_nxt;
  logic [16:0]       w_level17;
  logic [16:0]       w_sus17;
  logic              w_rise;
  logic              w_fall_evt;
  logic              w_clear;
  logic              w_step;
  logic [RATE_W-1:0] w_rate;

  assign w_level17  = {1'b0, r_level};
  assign w_sus17    = sustain_to_level(i_sustain);
  assign w_rise     = i_gate & ~r_gate_q;
  assign w_fall_evt = ~i_gate & r_gate_q &
                      ((r_stage == ST_ATTACK) || (r_stage == ST_DECAY) ||
                       (r_stage == ST_SUSTAIN));
  // Stages without a rate hold the prescaler at zero so the next stage starts clean.
  assign w_clear    = w_rise | w_fall_evt | (r_stage == ST_IDLE) |
                      (r_stage == ST_SUSTAIN);

  always_comb begin
    w_rate = '0;
    case (r_stage)
      ST_ATTACK:  w_rate = i_attack;
      ST_DECAY:   w_rate = i_decay;
      ST_RELEASE: w_rate = i_release;
      default:    w_rate = '0;
    endcase
  end

  adsr_rate_divider #(.RATE_W(RATE_W)) u_div (
    .clock   (clock),
    .reset   (reset),
    .i_tick  (i_tick),
    .i_clear (w_clear),
    .i_rate  (w_rate),
    .o_step  (w_step)
  );

  always_comb begin
    w_stage_nxt = r_stage;
    w_level_nxt = r_level;
    if (w_rise) begin
      w_stage_nxt = ST_ATTACK;
`ifdef ADSR_RETRIGGER_EN
      w_level_nxt = 16'd0;
`endif
    end else if (w_fall_evt) begin
      w_stage_nxt = ST_RELEASE;
    end else begin
      case (r_stage)
        ST_IDLE: w_level_nxt = 16'd0;
        ST_ATTACK: begin
          if (w_step) begin
            if (w_level17 >= ATK_TOP) begin
              w_level_nxt = LEVEL_MAX;
              w_stage_nxt = ST_DECAY;
            end else begin
              w_level_nxt = sat_add(w_level17, STEP17);
            end
          end
        end
        ST_DECAY: begin
          if (w_step) begin
            if ({1'b0, w_level17} <= ({1'b0, w_sus17} + {1'b0, STEP17})) begin
              w_level_nxt = w_sus17[15:0];
              w_stage_nxt = ST_SUSTAIN;
            end else begin
              w_level_nxt = sat_sub(w_level17, STEP17);
            end
          end
        end
        ST_SUSTAIN: if (i_tick) w_level_nxt = w_sus17[15:0];
        ST_RELEASE: begin
          if (w_step) begin
            if (w_level17 <= STEP17) begin
              w_level_nxt = 16'd0;
              w_stage_nxt = ST_IDLE;
            end else begin
              w_level_nxt = sat_sub(w_level17, STEP17);
            end
          end
        end
        default: begin
          w_level_nxt = 16'd0;
          w_stage_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stage  <= ST_IDLE;
      r_level  <= 16'd0;
      r_gate_q <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_stage  <= w_stage_nxt;
      r_level  <= w_level_nxt;
      r_gate_q <= i_gate;
      r_active <= (w_stage_nxt != ST_IDLE);
    end
  end

  assign o_level  = r_level;
  assign o_stage  = r_stage;
  assign o_active = r_active;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: a cycle table for short envelopes plus
// hand-written sequences for full attack/decay/sustain/release and corners.
module tb_adsr_envelope;

`ifdef ADSR_RETRIGGER_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        gate;
  logic [11:0] attack, decay, rel;
  logic [6:0]  sustain;
  logic [15:0] level;
  logic [2:0]  stage;
  logic        active;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adsr_envelope #(.LEVEL_STEP(256), .RATE_W(12)) dut (
    .clock     (clk),
    .reset     (reset),
    .i_tick    (tick),
    .i_gate    (gate),
    .i_attack  (attack),
    .i_decay   (decay),
    .i_sustain (sustain),
    .i_release (rel),
    .o_level   (level),
    .o_stage   (stage),
    .o_active  (active)
  );

  typedef struct {
    logic t;
    logic g;
    int   lvl;
    int   stg;
    int   act;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic g);
    @(negedge clk);
    tick = t;
    gate = g;
    @(posedge clk);
    #1;
  endtask

  int n;
  int exp_lvl;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 0,   0, 0};
    tbl[1]  = '{1'b0, 1'b1, 0,   1, 1};
    tbl[2]  = '{1'b1, 1'b1, 256, 1, 1};
    tbl[3]  = '{1'b1, 1'b1, 512, 1, 1};
    tbl[4]  = '{1'b0, 1'b1, 512, 1, 1};
    tbl[5]  = '{1'b1, 1'b1, 768, 1, 1};
    tbl[6]  = '{1'b1, 1'b0, 768, 4, 1};
    tbl[7]  = '{1'b1, 1'b0, 512, 4, 1};
    tbl[8]  = '{1'b1, 1'b0, 256, 4, 1};
    tbl[9]  = '{1'b1, 1'b0, 0,   0, 0};
    tbl[10] = '{1'b1, 1'b0, 0,   0, 0};
    tbl[11] = '{1'b1, 1'b1, 0,   1, 1};
    tbl[12] = '{1'b1, 1'b1, 256, 1, 1};
    tbl[13] = '{1'b0, 1'b0, 256, 4, 1};
    tbl[14] = '{1'b0, 1'b1, RT ? 0 : 256,   1, 1};
    tbl[15] = '{1'b1, 1'b1, RT ? 256 : 512, 1, 1};

    reset = 1'b1; tick = 1'b0; gate = 1'b0;
    attack = '0; decay = '0; rel = '0; sustain = 7'd50;
    @(posedge clk); #1;
    chk("rst_level", level, 0);
    chk("rst_stage", stage, 0);
    chk("rst_active", active, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].t, tbl[i].g);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("tbl%0d_stage", i), stage, tbl[i].stg);
      chk($sformatf("tbl%0d_active", i), active, tbl[i].act);
    end

    n = 0;
    while (stage != 3'd0 && n < 10) begin cyc(1'b1, 1'b0); n++; end
    chk("tbl_drain_stage", stage, 0);
    chk("tbl_drain_level", level, 0);

    // Full attack with one step per tick
    cyc(1'b0, 1'b1);
    chk("atk_enter_stage", stage, 1);
    for (int k = 1; k <= 256; k++) begin
      cyc(1'b1, 1'b1);
      if (k == 1)   chk("atk_k1", level, 256);
      if (k == 255) begin chk("atk_k255", level, 65280); chk("atk_k255_stage", stage, 1); end
      if (k == 256) begin chk("atk_peak", level, 65535); chk("atk_to_decay", stage, 2); end
    end

    n = 0;
    while (stage != 3'd3 && n < 300) begin cyc(1'b1, 1'b1); n++; end
    chk("decay_ticks", n, 129);
    chk("decay_sus_level", level, 32750);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("sus_hold_level", level, 32750);
    chk("sus_hold_stage", stage, 3);
    sustain = 7'd120;
    cyc(1'b0, 1'b1);
    chk("sus_no_tick", level, 32750);
    cyc(1'b1, 1'b1);
    chk("sus_clamp", level, 65500);
    sustain = 7'd50;
    cyc(1'b1, 1'b1);
    chk("sus_back", level, 32750);

    // Release at one step per two ticks; the fall edge itself takes no step
    rel = 12'd1;
    cyc(1'b1, 1'b0);
    chk("rel_enter_stage", stage, 4);
    chk("rel_enter_level", level, 32750);
    cyc(1'b1, 1'b0);
    chk("rel_t1", level, 32750);
    cyc(1'b1, 1'b0);
    chk("rel_t2", level, 32494);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("rel_t4", level, 32238);
    n = 0;
    while (stage != 3'd0 && n < 400) begin cyc(1'b1, 1'b0); n++; end
    chk("rel_ticks", n, 252);
    chk("rel_end_level", level, 0);
    chk("rel_end_active", active, 0);

    // Retrigger during release
    rel = 12'd0;
    cyc(1'b0, 1'b1);
    n = 0;
    while (stage != 3'd3 && n < 500) begin cyc(1'b1, 1'b1); n++; end
    chk("rt_sus_level", level, 32750);
    cyc(1'b0, 1'b0);
    chk("rt_rel_stage", stage, 4);
    for (int k = 0; k < 89; k++) cyc(1'b1, 1'b0);
    chk("rt_rel_level", level, 9966);
    chk("rt_rel_stage2", stage, 4);
    cyc(1'b0, 1'b1);
    chk("rt_stage", stage, 1);
    chk("rt_level", level, RT ? 0 : 9966);
    cyc(1'b1, 1'b1);
    chk("rt_step", level, RT ? 256 : 10222);

    // Asynchronous reset mid-attack near 20000
    n = RT ? 77 : 38;
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b1);
    exp_lvl = (RT ? 256 : 10222) + 256 * n;
    chk("pre_rst_level", level, exp_lvl);
    @(negedge clk);
    tick = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_level", level, 0);
    chk("async_rst_stage", stage, 0);
    chk("async_rst_active", active, 0);
    cyc(1'b0, 1'b1);
    chk("rst_held_stage", stage, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b1);
    chk("post_rst_rise_stage", stage, 1);
    chk("post_rst_rise_level", level, 0);

    // Gate rise colliding with a tick, slower attack rate
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("coll_idle", stage, 0);
    attack = 12'd3;
    cyc(1'b1, 1'b1);
    chk("coll_stage", stage, 1);
    chk("coll_level", level, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 1'b1);
      if (k < 4) chk($sformatf("coll_wait%0d", k), level, 0);
      else       chk("coll_first_step", level, 256);
    end
    attack = 12'd1;
    cyc(1'b1, 1'b1);
    chk("rate_live_wait", level, 256);
    cyc(1'b1, 1'b1);
    chk("rate_live_step", level, 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
